mem_wb_stage: RTL and testbench

// - Consumes EXE stage results (ALU result, store data, control) and returns the write-back pair to ID:
//   wb_result_out with wr_reg_en_out and wb_rd_out.
// - Contains the EXE/MEM pipeline register, a data-memory request/acknowledge master and the write-back select.
// - Stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_req_fsm.sv | 81 ++++++++
 rtl/mem_wb_stage.sv | 112 +++++++++++
 tb/tb_mem_wb_stage.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM/WB stage: FSM states, default widths and the latched EXE operation.
package mem_stage_pkg;

  localparam int unsigned ArqDefault     = 16;
  localparam int unsigned MemAddrDefault = 13;
  localparam int unsigned RegWDefault    = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, WB} mem_state_t;

  typedef struct packed {
    logic [ArqDefault-1:0]  alu_result;
    logic [ArqDefault-1:0]  store_data;
    logic                   wb_en;
    logic [RegWDefault-1:0] rd;
    logic                   we;
    logic                   mux_mem;
    logic                   is_mem;
  } mem_op_t;

endpackage

// File: rtl/mem_req_fsm.sv
// Memory request/acknowledge master: owns the stage state, the ack wait counter,
// the request strobes, the timeout error pulse and the upstream stall.
module mem_req_fsm
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic exe_valid_i,
  input  logic new_is_mem_i,
  input  logic op_we_i,
  input  logic op_is_mem_i,
  input  logic mem_ack_i,
  output logic capture_o,
  output logic load_done_o,
  output logic stall_o,
  output logic mem_req_o,
  output logic mem_we_o,
  output logic mem_err_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            timeout_hit;

  // TIMEOUT == 0 disables the abort entirely.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    load_done_o = 1'b0;
    capture_o   = exe_valid_i && (state_q != ACCESS);
    unique case (state_q)
      ACCESS: begin
        // An ack on the final count takes priority over the timeout.
        if (mem_ack_i) begin
          state_d     = op_we_i ? IDLE : WB;
          load_done_o = op_is_mem_i & ~op_we_i;
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (capture_o) begin
          state_d = new_is_mem_i ? ACCESS : WB;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Decoded straight from the state register so reset drops the request at once.
  assign stall_o   = (state_q == ACCESS);
  assign mem_req_o = (state_q == ACCESS);
  assign mem_we_o  = (state_q == ACCESS) & op_we_i;
  assign mem_err_o = err_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: EXE/MEM operation register, data-memory master and
// write-back select returning the register-write pair to ID.
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ARQ              = ArqDefault,
  parameter int unsigned MEMORY_ADDR_SIZE = MemAddrDefault,
  parameter int unsigned REG_W            = RegWDefault,
  parameter int unsigned TIMEOUT          = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        exe_valid,
  input  logic [ARQ-1:0]              alu_result,
  input  logic [ARQ-1:0]              store_data,
  input  logic                        wb_en_in,
  input  logic                        rd_mem_en_in,
  input  logic                        wr_mem_en_in,
  input  logic                        mux_mem_in,
  input  logic [REG_W-1:0]            rd_in,
  output logic                        stall_out,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
  output logic [ARQ-1:0]              mem_wdata,
  input  logic                        mem_ack,
  input  logic [ARQ-1:0]              mem_rdata,
  output logic                        mem_err,
  output logic [ARQ-1:0]              wb_result_out,
  output logic                        wr_reg_en_out,
  output logic [REG_W-1:0]            wb_rd_out
);

  mem_op_t          new_op, op_q;
  logic             capture, load_done;
  logic [ARQ-1:0]   wb_result_q, wb_result_d;
  logic [REG_W-1:0] wb_rd_q, wb_rd_d;
  logic             wb_en_q, wb_en_d;

  // Load and store both set is treated as a store.
  always_comb begin
    new_op            = '0;
    new_op.alu_result = alu_result;
    new_op.store_data = store_data;
    new_op.wb_en      = wb_en_in;
    new_op.rd         = rd_in;
    new_op.we         = wr_mem_en_in;
    new_op.mux_mem    = mux_mem_in;
    new_op.is_mem     = rd_mem_en_in | wr_mem_en_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q <= '0;
    end else if (capture) begin
      op_q <= new_op;
    end
  end

  mem_req_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_req_fsm (
    .clk_i        (clk),
    .rst_ni       (rst),
    .exe_valid_i  (exe_valid),
    .new_is_mem_i (new_op.is_mem),
    .op_we_i      (op_q.we),
    .op_is_mem_i  (op_q.is_mem),
    .mem_ack_i    (mem_ack),
    .capture_o    (capture),
    .load_done_o  (load_done),
    .stall_o      (stall_out),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_err_o    (mem_err)
  );

  // ALU results bypass the memory and write back the cycle after capture.
  always_comb begin
    wb_result_d = wb_result_q;
    wb_rd_d     = wb_rd_q;
    wb_en_d     = 1'b0;
    if (capture && !new_op.is_mem) begin
      wb_en_d     = wb_en_in;
      wb_result_d = alu_result;
      wb_rd_d     = rd_in;
    end else if (load_done) begin
      wb_en_d     = op_q.wb_en;
      wb_result_d = op_q.mux_mem ? mem_rdata : op_q.alu_result;
      wb_rd_d     = op_q.rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_result_q <= '0;
      wb_rd_q     <= '0;
      wb_en_q     <= 1'b0;
    end else begin
      wb_result_q <= wb_result_d;
      wb_rd_q     <= wb_rd_d;
      wb_en_q     <= wb_en_d;
    end
  end

  assign wb_result_out = wb_result_q;
  assign wb_rd_out     = wb_rd_q;
  assign wr_reg_en_out = wb_en_q;
  assign mem_addr      = op_q.alu_result[MEMORY_ADDR_SIZE-1:0];
  assign mem_wdata     = op_q.store_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a randomized
// op stream checked against an in-order write-back queue model.
module tb_mem_wb_stage;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exe_valid;
  logic [15:0] alu_result;
  logic [15:0] store_data;
  logic        wb_en_in;
  logic        rd_mem_en_in;
  logic        wr_mem_en_in;
  logic        mux_mem_in;
  logic [3:0]  rd_in;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_err;
  logic [15:0] wb_result_out;
  logic        wr_reg_en_out;
  logic [3:0]  wb_rd_out;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] alu;
    logic [15:0] sd;
    logic        wb;
    logic        rdm;
    logic        wrm;
    logic        mux;
    logic [3:0]  rd;
    int          lat;
  } op_t;

  mem_wb_stage #(
    .ARQ              (16),
    .MEMORY_ADDR_SIZE (13),
    .REG_W            (4),
    .TIMEOUT          (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .exe_valid     (exe_valid),
    .alu_result    (alu_result),
    .store_data    (store_data),
    .wb_en_in      (wb_en_in),
    .rd_mem_en_in  (rd_mem_en_in),
    .wr_mem_en_in  (wr_mem_en_in),
    .mux_mem_in    (mux_mem_in),
    .rd_in         (rd_in),
    .stall_out     (stall_out),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .mem_err       (mem_err),
    .wb_result_out (wb_result_out),
    .wr_reg_en_out (wr_reg_en_out),
    .wb_rd_out     (wb_rd_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exe_valid    = 1'b0;
    alu_result   = '0;
    store_data   = '0;
    wb_en_in     = 1'b0;
    rd_mem_en_in = 1'b0;
    wr_mem_en_in = 1'b0;
    mux_mem_in   = 1'b0;
    rd_in        = '0;
  endtask

  task automatic present(input logic [15:0] alu, input logic [15:0] sd, input logic wb,
                         input logic rdm, input logic wrm, input logic mux,
                         input logic [3:0] rd);
    exe_valid    = 1'b1;
    alu_result   = alu;
    store_data   = sd;
    wb_en_in     = wb;
    rd_mem_en_in = rdm;
    wr_mem_en_in = wrm;
    mux_mem_in   = mux;
    rd_in        = rd;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({mem_req, mem_we, mem_err, stall_out, wr_reg_en_out} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {mem_req, mem_we, mem_err, stall_out, wr_reg_en_out});
    end
    vectors++;
    if ({wb_result_out, wb_rd_out, mem_addr, mem_wdata} !== 49'b0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0",
               {wb_result_out, wb_rd_out, mem_addr, mem_wdata});
    end
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_alu();
    present(16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
    vectors++;
    if (stall_out !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_nostall_pre: got %b required 0", stall_out);
    end
    step();
    clear_inputs();
    vectors++;
    if ({wr_reg_en_out, wb_result_out, wb_rd_out, stall_out} !== {1'b1, 16'h1234, 4'd3, 1'b0})
    begin
      miscompares++;
      $display("FAIL alu_wb: got %h required %h", {wr_reg_en_out, wb_result_out, wb_rd_out,
               stall_out}, {1'b1, 16'h1234, 4'd3, 1'b0});
    end
    step();
    vectors++;
    if ({wr_reg_en_out, stall_out} !== 2'b00) begin
      miscompares++;
      $display("FAIL alu_single_strobe: got %b required 00", {wr_reg_en_out, stall_out});
    end
  endtask

  task automatic test_load();
    present(16'h0042, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
    step();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({stall_out, mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 13'h0042}) begin
        miscompares++;
        $display("FAIL load_access%0d: got %h required %h", k,
                 {stall_out, mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 13'h0042});
      end
      if (k == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
      end
      step();
    end
    mem_ack = 1'b0;
    vectors++;
    if ({stall_out, wr_reg_en_out, wb_result_out, wb_rd_out} !== {1'b0, 1'b1, 16'hBEEF, 4'd5})
    begin
      miscompares++;
      $display("FAIL load_wb: got %h required %h", {stall_out, wr_reg_en_out, wb_result_out,
               wb_rd_out}, {1'b0, 1'b1, 16'hBEEF, 4'd5});
    end
    step();
    vectors++;
    if (wr_reg_en_out !== 1'b0) begin
      miscompares++;
      $display("FAIL load_single_strobe: got %b required 0", wr_reg_en_out);
    end
  endtask

  task automatic test_store();
    present(16'h1FFF, 16'hA5A5, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6);
    step();
    clear_inputs();
    vectors++;
    if ({stall_out, mem_req, mem_we, mem_addr, mem_wdata} !==
        {1'b1, 1'b1, 1'b1, 13'h1FFF, 16'hA5A5}) begin
      miscompares++;
      $display("FAIL store_req: got %h required %h",
               {stall_out, mem_req, mem_we, mem_addr, mem_wdata},
               {1'b1, 1'b1, 1'b1, 13'h1FFF, 16'hA5A5});
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    vectors++;
    if ({stall_out, mem_req, mem_we, wr_reg_en_out} !== 4'b0000) begin
      miscompares++;
      $display("FAIL store_done: got %b required 0000",
               {stall_out, mem_req, mem_we, wr_reg_en_out});
    end
    step();
    vectors++;
    if ({wr_reg_en_out, mem_addr} !== {1'b0, 13'h1FFF}) begin
      miscompares++;
      $display("FAIL store_hold: got %h required %h", {wr_reg_en_out, mem_addr},
               {1'b0, 13'h1FFF});
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int errs       = 0;
    int strobes    = 0;
    int last_req   = -1;
    int err_at     = -1;
    present(16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7);
    step();
    clear_inputs();
    for (int c = 0; c < 40; c++) begin
      if (mem_req) begin
        req_cycles++;
        last_req = c;
      end
      if (mem_err) begin
        errs++;
        err_at = c;
      end
      if (wr_reg_en_out) strobes++;
      step();
    end
    vectors++;
    if (req_cycles != int'(TO)) begin
      miscompares++;
      $display("FAIL timeout_req_cycles: got %0d required %0d", req_cycles, TO);
    end
    vectors++;
    if (errs != 1 || err_at != last_req + 1) begin
      miscompares++;
      $display("FAIL timeout_err_pulse: got %0d pulses at %0d, required 1 at %0d",
               errs, err_at, last_req + 1);
    end
    vectors++;
    if (strobes != 0 || stall_out !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_no_wb: got strobes=%0d stall=%b required 0/0", strobes, stall_out);
    end
  endtask

  task automatic test_reset_mid_access();
    logic bad = 1'b0;
    present(16'h0200, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9);
    step();
    clear_inputs();
    step();
    step();
    vectors++;
    if ({mem_req, stall_out} !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_pre_access: got %b required 11", {mem_req, stall_out});
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({mem_req, stall_out, mem_we, mem_err, wr_reg_en_out} !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_async_drop: got %b required 00000",
               {mem_req, stall_out, mem_we, mem_err, wr_reg_en_out});
    end
    mem_ack   = 1'b1;
    mem_rdata = 16'h7777;
    step();
    rst = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bad = bad | wr_reg_en_out | mem_req;
      step();
    end
    vectors++;
    if ({bad, wb_rd_out} !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_ack_ignored: got %h required 0", {bad, wb_rd_out});
    end
  endtask

  task automatic test_back_to_back();
    present(16'h1111, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    step();
    present(16'h2222, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    vectors++;
    if ({wr_reg_en_out, wb_rd_out, wb_result_out} !== {1'b1, 4'd1, 16'h1111}) begin
      miscompares++;
      $display("FAIL b2b_first: got %h required %h", {wr_reg_en_out, wb_rd_out, wb_result_out},
               {1'b1, 4'd1, 16'h1111});
    end
    step();
    present(16'h3333, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
    vectors++;
    if ({wr_reg_en_out, wb_rd_out, wb_result_out} !== {1'b1, 4'd2, 16'h2222}) begin
      miscompares++;
      $display("FAIL b2b_second: got %h required %h", {wr_reg_en_out, wb_rd_out, wb_result_out},
               {1'b1, 4'd2, 16'h2222});
    end
    step();
    clear_inputs();
    vectors++;
    if ({wr_reg_en_out, wb_rd_out, wb_result_out} !== {1'b1, 4'd3, 16'h3333}) begin
      miscompares++;
      $display("FAIL b2b_third: got %h required %h", {wr_reg_en_out, wb_rd_out, wb_result_out},
               {1'b1, 4'd3, 16'h3333});
    end
    step();
    vectors++;
    if (wr_reg_en_out !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: got %b required 0", wr_reg_en_out);
    end
  endtask

  // Ops are presented and held while stalled; the model records each write-back
  // the op should produce, in order, and the number of timeout aborts.
  task automatic test_random();
    op_t         pend;
    op_t         cur;
    logic        captured_next = 1'b0;
    int          acc_k         = 0;
    int          exp_err       = 0;
    int          got_err       = 0;
    int unsigned kind;
    int unsigned r;
    logic [19:0] e;
    logic [19:0] exp_q[$];
    pend = '{alu: '0, sd: '0, wb: 1'b0, rdm: 1'b0, wrm: 1'b0, mux: 1'b0, rd: '0, lat: 0};
    cur  = pend;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (captured_next) begin
        if (pend.rdm || pend.wrm) begin
          cur   = pend;
          acc_k = 0;
        end else if (pend.wb) begin
          exp_q.push_back({pend.rd, pend.alu});
        end
      end
      if (mem_err) got_err++;
      if (wr_reg_en_out) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_strobe: got unexpected rd=%0d value=%h, required none",
                   wb_rd_out, wb_result_out);
        end else begin
          e = exp_q.pop_front();
          if ({wb_rd_out, wb_result_out} !== e) begin
            miscompares++;
            $display("FAIL rand_strobe: got %h required %h", {wb_rd_out, wb_result_out}, e);
          end
        end
      end
      mem_ack = 1'b0;
      if (mem_req) begin
        acc_k++;
        vectors++;
        if ({mem_we, mem_addr, mem_wdata} !== {cur.wrm, cur.alu[12:0], cur.sd}) begin
          miscompares++;
          $display("FAIL rand_mem_req: got %h required %h", {mem_we, mem_addr, mem_wdata},
                   {cur.wrm, cur.alu[12:0], cur.sd});
        end
        if (acc_k == cur.lat && acc_k <= int'(TO)) begin
          mem_ack   = 1'b1;
          mem_rdata = 16'($urandom);
          if (cur.rdm && !cur.wrm && cur.wb)
            exp_q.push_back({cur.rd, cur.mux ? mem_rdata : cur.alu});
        end else if (acc_k == int'(TO)) begin
          exp_err++;
        end
      end else begin
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = 16'($urandom);
      end
      if (captured_next || !exe_valid) begin
        if (cyc < 2800 && $urandom_range(0, 3) != 0) begin
          kind     = $urandom_range(0, 9);
          r        = $urandom_range(0, 9);
          pend.alu = 16'($urandom);
          pend.sd  = 16'($urandom);
          pend.rd  = 4'($urandom);
          pend.wb  = 1'($urandom);
          pend.mux = 1'($urandom);
          pend.rdm = (kind >= 4 && kind <= 6) || kind == 9;
          pend.wrm = (kind >= 7);
          pend.lat = (r < 7) ? int'($urandom_range(1, 4)) : (r == 7) ? int'(TO) : 100;
          present(pend.alu, pend.sd, pend.wb, pend.rdm, pend.wrm, pend.mux, pend.rd);
        end else begin
          clear_inputs();
        end
      end
      captured_next = exe_valid && !stall_out;
      step();
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_missing_wb: got %0d write-backs outstanding, required 0",
               exp_q.size());
    end
    vectors++;
    if (got_err != exp_err) begin
      miscompares++;
      $display("FAIL rand_err_count: got %0d required %0d", got_err, exp_err);
    end
  endtask

  initial begin
    clear_inputs();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
